chien_root_scan: RTL and testbench

Sequencer and root detector that sits directly downstream of the three Chien evaluation cells of the RS(15,11) decoder over GF(16), with primitive polynomial x^4+x+1 and t=2. It drives the cells' shared CONTROL line and sums their outputs each cycle. It flags every codeword position whose locator evaluation is zero and reports an error mask, an error count and a decoding-failure flag for the Forney/correction stage.

---
 rtl/chien_root_scan_if.sv | 31 +++
 rtl/chien_root_scan.sv | 134 +++++++++++++
 tb/tb_chien_root_scan.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/chien_root_scan_if.sv
// Bundled handshake, Chien-cell and result signals of the RS(15,11) Chien root scanner.
// The scanner uses the slave view; the driving environment uses the master view.
interface chien_root_scan_if #(
  parameter int N = 15,
  parameter int M = 4
);
  logic         START;
  logic [1:0]   LAMBDA_DEG;
  logic [M-1:0] CHIEN_0;
  logic [M-1:0] CHIEN_1;
  logic [M-1:0] CHIEN_2;
  logic         CONTROL;
  logic         BUSY;
  logic         POS_VALID;
  logic [3:0]   POS;
  logic         ERR_LOC;
  logic         DONE;
  logic [N-1:0] ERR_MASK;
  logic [3:0]   ERR_COUNT;
  logic         FAIL;

  modport slave (
    input  START, LAMBDA_DEG, CHIEN_0, CHIEN_1, CHIEN_2,
    output CONTROL, BUSY, POS_VALID, POS, ERR_LOC, DONE, ERR_MASK, ERR_COUNT, FAIL
  );

  modport master (
    output START, LAMBDA_DEG, CHIEN_0, CHIEN_1, CHIEN_2,
    input  CONTROL, BUSY, POS_VALID, POS, ERR_LOC, DONE, ERR_MASK, ERR_COUNT, FAIL
  );
endinterface

// File: rtl/chien_root_scan.sv
// Chien search sequencer for RS(15,11) over GF(16): steps the evaluation cells through
// alpha^1..alpha^15, flags locator roots and reports mask, count and failure status.
module chien_root_scan #(
  parameter int N = 15,
  parameter int M = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  chien_root_scan_if.slave  bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [N-1:0] MASK_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [3:0]   STEP_LAST = 4'd15;

  state_t       state_q;
  logic [3:0]   i_q;
  logic [1:0]   deg_q;
  logic         control_q;
  logic         busy_q;
  logic         pos_valid_q;
  logic [3:0]   pos_q;
  logic         err_loc_q;
  logic         done_q;
  logic [N-1:0] mask_q;
  logic [3:0]   count_q;
  logic         fail_q;

  logic [M-1:0] sum_d;
  logic         root_d;
  logic [3:0]   pos_d;
  logic [3:0]   count_d;
  logic [N-1:0] mask_d;
  logic         fail_d;

  // Locator evaluation at alpha^i and the result bookkeeping it would produce
  always_comb begin
    sum_d  = bus.CHIEN_0 ^ bus.CHIEN_1 ^ bus.CHIEN_2;
    root_d = (sum_d == {M{1'b0}});
    // alpha^i is a root for position (15 - i) mod 15; i = 15 wraps to 0
    pos_d  = STEP_LAST - i_q;
    if (root_d && (count_q != 4'd15)) begin
      count_d = count_q + 4'd1;
    end else begin
      count_d = count_q;
    end
    if (root_d) begin
      mask_d = mask_q | (MASK_ONE << pos_d);
    end else begin
      mask_d = mask_q;
    end
    fail_d = (count_d != {2'b00, deg_q});
  end

  // Scan FSM with all outputs registered
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      i_q         <= 4'd0;
      deg_q       <= 2'd0;
      control_q   <= 1'b1;
      busy_q      <= 1'b0;
      pos_valid_q <= 1'b0;
      pos_q       <= 4'd0;
      err_loc_q   <= 1'b0;
      done_q      <= 1'b0;
      mask_q      <= {N{1'b0}};
      count_q     <= 4'd0;
      fail_q      <= 1'b0;
    end else begin
      pos_valid_q <= 1'b0;
      pos_q       <= 4'd0;
      err_loc_q   <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.START) begin
            state_q   <= ST_SCAN;
            i_q       <= 4'd1;
            deg_q     <= bus.LAMBDA_DEG;
            mask_q    <= {N{1'b0}};
            count_q   <= 4'd0;
            fail_q    <= 1'b0;
            control_q <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            control_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        ST_SCAN: begin
          pos_valid_q <= 1'b1;
          pos_q       <= pos_d;
          err_loc_q   <= root_d;
          mask_q      <= mask_d;
          count_q     <= count_d;
          if (i_q == STEP_LAST) begin
            state_q   <= ST_IDLE;
            i_q       <= 4'd0;
            done_q    <= 1'b1;
            fail_q    <= fail_d;
            control_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            i_q       <= i_q + 4'd1;
            control_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          i_q       <= 4'd0;
          control_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CONTROL   = control_q;
  assign bus.BUSY      = busy_q;
  assign bus.POS_VALID = pos_valid_q;
  assign bus.POS       = pos_q;
  assign bus.ERR_LOC   = err_loc_q;
  assign bus.DONE      = done_q;
  assign bus.ERR_MASK  = mask_q;
  assign bus.ERR_COUNT = count_q;
  assign bus.FAIL      = fail_q;

endmodule

// File: tb/tb_chien_root_scan.sv
// Directed bench for chien_root_scan: models the three Chien cells (x alpha^0..alpha^2)
// and checks every result cycle against hand-derived root positions.
module tb_chien_root_scan;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  chien_root_scan_if #(.N(15), .M(4)) bus_if ();
  chien_root_scan #(.N(15), .M(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus_if));

  int checks = 0;
  int errors = 0;

  logic [3:0] lam0 = 4'd0, lam1 = 4'd0, lam2 = 4'd0;
  logic [3:0] cell0, cell1, cell2;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'd0;
    aa = a;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) p = p ^ aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
    end
    return p;
  endfunction

  // Chien cells: load lambda_k*alpha^k when CONTROL=1, else multiply by alpha^k
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cell0 <= 4'd0; cell1 <= 4'd0; cell2 <= 4'd0;
    end else if (bus_if.CONTROL) begin
      cell0 <= lam0;
      cell1 <= gf_mul(lam1, 4'h2);
      cell2 <= gf_mul(lam2, 4'h4);
    end else begin
      cell1 <= gf_mul(cell1, 4'h2);
      cell2 <= gf_mul(cell2, 4'h4);
    end
  end

  assign bus_if.CHIEN_0 = cell0;
  assign bus_if.CHIEN_1 = cell1;
  assign bus_if.CHIEN_2 = cell2;

  task automatic test_reset;
    bus_if.START = 1'b0;
    bus_if.LAMBDA_DEG = 2'd0;
    RESET = 1'b1;
    #12;
    checks++; if (bus_if.CONTROL !== 1'b1) begin errors++; $display("FAIL reset_control got %b want 1", bus_if.CONTROL); end
    checks++; if ({bus_if.BUSY, bus_if.POS_VALID, bus_if.ERR_LOC, bus_if.DONE, bus_if.FAIL} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {bus_if.BUSY, bus_if.POS_VALID, bus_if.ERR_LOC, bus_if.DONE, bus_if.FAIL}); end
    checks++; if ({bus_if.POS, bus_if.ERR_MASK, bus_if.ERR_COUNT} !== 23'd0) begin
      errors++; $display("FAIL reset_values pos=%0d mask=%h cnt=%0d want all 0", bus_if.POS, bus_if.ERR_MASK, bus_if.ERR_COUNT); end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      checks++; if ({bus_if.CONTROL, bus_if.BUSY, bus_if.POS_VALID, bus_if.DONE} !== 4'b1000) begin
        errors++; $display("FAIL idle ctl/busy/valid/done got %b want 1000", {bus_if.CONTROL, bus_if.BUSY, bus_if.POS_VALID, bus_if.DONE}); end
    end
  endtask

  // Arms START at the current negedge; returns at the negedge of the DONE cycle
  task automatic test_scan(input string name, input logic [3:0] l0, input logic [3:0] l1, input logic [3:0] l2,
                           input logic [1:0] deg, input logic [14:0] exp_mask, input logic [3:0] exp_cnt,
                           input logic exp_fail, input bit pulse_mid);
    logic [3:0] exp_pos;
    lam0 = l0; lam1 = l1; lam2 = l2;
    bus_if.LAMBDA_DEG = deg;
    bus_if.START = 1'b1;
    @(negedge CLK);
    bus_if.START = 1'b0;
    lam0 = 4'h5; lam1 = 4'h9; lam2 = 4'hC;
    bus_if.LAMBDA_DEG = 2'd3;
    checks++; if ({bus_if.CONTROL, bus_if.BUSY, bus_if.POS_VALID} !== 3'b010) begin
      errors++; $display("FAIL %s start_cycle ctl/busy/valid got %b want 010", name, {bus_if.CONTROL, bus_if.BUSY, bus_if.POS_VALID}); end
    checks++; if ({bus_if.ERR_MASK, bus_if.ERR_COUNT, bus_if.FAIL} !== 20'd0) begin
      errors++; $display("FAIL %s start_clear mask=%h cnt=%0d flag=%b want 0", name, bus_if.ERR_MASK, bus_if.ERR_COUNT, bus_if.FAIL); end
    for (int k = 1; k <= 15; k++) begin
      bus_if.START = pulse_mid && (k == 5 || k == 6);
      @(negedge CLK);
      exp_pos = 4'(15 - k);
      checks++; if (bus_if.POS_VALID !== 1'b1 || bus_if.POS !== exp_pos) begin
        errors++; $display("FAIL %s step%0d valid=%b pos=%0d want 1/%0d", name, k, bus_if.POS_VALID, bus_if.POS, exp_pos); end
      checks++; if (bus_if.ERR_LOC !== exp_mask[exp_pos]) begin
        errors++; $display("FAIL %s step%0d err_loc got %b want %b", name, k, bus_if.ERR_LOC, exp_mask[exp_pos]); end
      checks++; if (bus_if.DONE !== (k == 15) || bus_if.BUSY !== (k != 15) || bus_if.CONTROL !== (k == 15)) begin
        errors++; $display("FAIL %s step%0d done/busy/ctl got %b%b%b", name, k, bus_if.DONE, bus_if.BUSY, bus_if.CONTROL); end
    end
    bus_if.START = 1'b0;
    checks++; if (bus_if.ERR_MASK !== exp_mask) begin
      errors++; $display("FAIL %s err_mask got %h want %h", name, bus_if.ERR_MASK, exp_mask); end
    checks++; if (bus_if.ERR_COUNT !== exp_cnt) begin
      errors++; $display("FAIL %s err_count got %0d want %0d", name, bus_if.ERR_COUNT, exp_cnt); end
    checks++; if (bus_if.FAIL !== exp_fail) begin
      errors++; $display("FAIL %s fail_flag got %b want %b", name, bus_if.FAIL, exp_fail); end
  endtask

  task automatic test_reset_mid;
    lam0 = 4'd1; lam1 = 4'd0; lam2 = 4'd1;
    bus_if.LAMBDA_DEG = 2'd2;
    bus_if.START = 1'b1;
    @(negedge CLK);
    bus_if.START = 1'b0;
    repeat (7) @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++; if ({bus_if.CONTROL, bus_if.BUSY, bus_if.POS_VALID, bus_if.ERR_LOC, bus_if.DONE} !== 5'b10000) begin
      errors++; $display("FAIL midreset ctl/busy/valid/loc/done got %b want 10000",
                         {bus_if.CONTROL, bus_if.BUSY, bus_if.POS_VALID, bus_if.ERR_LOC, bus_if.DONE}); end
    checks++; if ({bus_if.POS, bus_if.ERR_MASK, bus_if.ERR_COUNT, bus_if.FAIL} !== 24'd0) begin
      errors++; $display("FAIL midreset values pos=%0d mask=%h cnt=%0d want 0", bus_if.POS, bus_if.ERR_MASK, bus_if.ERR_COUNT); end
    @(negedge CLK);
    RESET = 1'b0;
    test_idle(10);
    test_scan("after_reset", 4'd1, 4'd7, 4'd6, 2'd2, 15'h0021, 4'd2, 1'b0, 1'b0);
  endtask

  initial begin
    bus_if.START = 1'b0;
    bus_if.LAMBDA_DEG = 2'd0;
    test_reset;
    test_scan("no_errors", 4'd1, 4'd0, 4'd0, 2'd0, 15'h0000, 4'd0, 1'b0, 1'b0);
    test_idle(2);
    test_scan("single", 4'd1, 4'd8, 4'd0, 2'd1, 15'h0008, 4'd1, 1'b0, 1'b0);
    test_idle(1);
    test_scan("two_errors", 4'd1, 4'd7, 4'd6, 2'd2, 15'h0021, 4'd2, 1'b0, 1'b0);
    test_idle(1);
    test_scan("double_root", 4'd1, 4'd0, 4'd1, 2'd2, 15'h0001, 4'd1, 1'b1, 1'b0);
    test_idle(1);
    test_scan("mid_start", 4'd1, 4'd7, 4'd6, 2'd2, 15'h0021, 4'd2, 1'b0, 1'b1);
    test_scan("back_to_back_deg3", 4'd1, 4'd8, 4'd0, 2'd3, 15'h0008, 4'd1, 1'b1, 1'b0);
    test_idle(3);
    test_scan("all_zero", 4'd0, 4'd0, 4'd0, 2'd0, 15'h7FFF, 4'd15, 1'b1, 1'b0);
    test_idle(1);
    test_reset_mid;
    test_idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
